// File: rtl/ind_pkg.sv
// Shared types and constants for the indicator sequencer and its prescaler.
package ind_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_STOP     = 2'b00,
        OP_RUN      = 2'b01,
        OP_BURST    = 2'b10,
        OP_LOAD_DIV = 2'b11
    } cmd_op_e;

    localparam logic [15:0] DEFAULT_DIV = 16'd49999;

endpackage

// File: rtl/ind_seq_ctrl_if.sv
// Command handshake between the register/command logic (master) and the sequencer (slave).
interface ind_seq_ctrl_if #(
    parameter int unsigned DIV_W = 16
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DIV_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/ind_seq_ctrl_prescaler.sv
// Period counter for the sequencer: counts cycles while active and raises a registered
// tick one cycle ahead, so the tick is visible during the cycle the step takes effect.
module ind_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_restart,
    input  logic             i_active,
    input  logic             i_active_next,
    input  logic [DIV_W-1:0] i_div_next,
    output logic             o_tick,
    output logic             o_tick_next
);

    logic [DIV_W-1:0] r_pcnt;
    logic [DIV_W-1:0] w_pcnt_next;
    logic             r_tick;

    always_comb begin
        w_pcnt_next = r_pcnt;
        if (i_restart || r_tick) begin
            w_pcnt_next = '0;
        end else if (i_active) begin
            w_pcnt_next = r_pcnt + DIV_W'(1);
        end
    end

    // >= rather than == so a divisor lowered below the running count fires at once.
    assign o_tick_next = i_active_next && (w_pcnt_next >= i_div_next);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pcnt <= w_pcnt_next;
            r_tick <= o_tick_next;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/ind_seq_ctrl.sv
// Indicator sequencer: accepts STOP/RUN/BURST/LOAD_DIV commands, issues step and clear
// strobes to the pattern generator and mirrors its 3-bit phase.
module ind_seq_ctrl #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = ind_pkg::DEFAULT_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    ind_seq_ctrl_if.slave        cmd,
    input  logic                 i_abort,
    output logic                 o_step_en,
    output logic                 o_seq_clr,
    output logic [2:0]           o_phase,
    output logic                 o_wrap,
    output logic                 o_busy
);

    import ind_pkg::*;

    state_e           r_state;
    state_e           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W-1:0] r_bcnt;
    logic [DIV_W-1:0] w_bcnt_next;
    logic [DIV_W-1:0] w_data;
    logic [2:0]       r_phase;
    logic [2:0]       w_phase_next;
    logic             r_seq_clr;
    logic             r_wrap;
    logic             r_busy;
    logic             r_cmd_ready;
    logic             r_abort_d;
    logic             w_tick;
    logic             w_tick_next;
    logic             w_accept;
    logic             w_restart;
    cmd_op_e          w_op;

    assign cmd.cmd_ready = r_cmd_ready & ~i_abort;
    assign w_accept      = cmd.cmd_valid & r_cmd_ready & ~i_abort;
    assign w_op          = cmd_op_e'(cmd.cmd_op);
    assign w_data        = DIV_W'(cmd.cmd_data);

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bcnt_next  = r_bcnt;
        w_restart    = 1'b0;
        w_phase_next = w_tick ? r_phase + 3'd1 : r_phase;
        if (i_abort) begin
            w_state_next = ST_IDLE;
            w_bcnt_next  = '0;
            w_phase_next = 3'd0;
            w_restart    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_RUN: begin
                                w_state_next = ST_RUN;
                                w_restart    = 1'b1;
                            end
                            OP_BURST: begin
                                if (w_data != '0) begin
                                    w_state_next = ST_BURST;
                                    w_bcnt_next  = w_data;
                                    w_restart    = 1'b1;
                                end
                            end
                            OP_LOAD_DIV: w_div_next = w_data;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_STOP:     w_state_next = ST_IDLE;
                            OP_LOAD_DIV: w_div_next   = w_data;
                            default:     w_restart    = 1'b1;
                        endcase
                    end
                end
                ST_BURST: begin
                    if (w_tick) begin
                        w_bcnt_next = r_bcnt - DIV_W'(1);
                        if (r_bcnt == DIV_W'(1)) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    ind_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk           (clk),
        .rst           (rst),
        .i_restart     (w_restart),
        .i_active      (r_state != ST_IDLE),
        .i_active_next (w_state_next != ST_IDLE),
        .i_div_next    (w_div_next),
        .o_tick        (w_tick),
        .o_tick_next   (w_tick_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_div       <= DIV_W'(DEFAULT_DIV);
            r_bcnt      <= '0;
            r_phase     <= 3'd0;
            r_seq_clr   <= 1'b0;
            r_wrap      <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_abort_d   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_div       <= w_div_next;
            r_bcnt      <= w_bcnt_next;
            r_phase     <= w_phase_next;
            r_seq_clr   <= i_abort & ~r_abort_d;
            r_wrap      <= w_tick_next && (w_phase_next == 3'd7);
            r_busy      <= (w_state_next != ST_IDLE);
            r_cmd_ready <= (w_state_next != ST_BURST);
            r_abort_d   <= i_abort;
        end
    end

    assign o_step_en = w_tick;
    assign o_seq_clr = r_seq_clr;
    assign o_phase   = r_phase;
    assign o_wrap    = r_wrap;
    assign o_busy    = r_busy;

endmodule
